instr_queue_decode: RTL and testbench
=====================================

// Module: instr_queue_decode
// PURPOSE
//  Consumer end of the fetch interface. Buffers {pc, instr} pairs from the fetch stage.
//  Decodes the 8-bit instruction and presents it to dispatch/rename with a valid/ready handshake.
//  Sits between fetch and the OOO dispatch stage.
//  Supplies backpressure to fetch, and is cleared by a branch-redirect flush.
// PARAMETERS
//  DEPTH  4  queue entries; power of 2, >=2
//  AW     2  pointer width = log2(DEPTH)
// PORTS
//  clk          in   1      clock, all state on posedge
//  rst_n        in   1      async active-low reset
//  f_valid      in   1      fetch offers f_pc/f_instr this cycle
//  f_pc         in   8      pc of offered instruction
//  f_instr      in   8      offered instruction
//  f_ready      out  1      queue accepts; push = f_valid & f_ready
//  flush        in   1      redirect: discard all entries
//  d_valid      out  1      head entry valid
//  d_ready      in   1      dispatch takes head; pop = d_valid & d_ready
//  d_pc         out  8      head pc
//  d_op         out  4      instr[7:4]
//  d_rd         out  2      instr[3:2]
//  d_rs         out  2      instr[1:0]
//  d_wr_en      out  1      op writes rd: ADD/SUB/AND/OR/XOR/LD
//  d_is_mem     out  1      LD or ST
//  d_is_branch  out  1      BEQ
//  d_illegal    out  1      op not in {0..8, F}
//  halted       out  1      HALT has been popped
//  count        out  AW+1   occupancy 0..DEPTH
// BEHAVIOUR
//  Opcode map: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 LD, 7 ST, 8 BEQ, F HALT; 9..E illegal.
//  Reset (async, rst_n=0): pointers=0, count=0, halted=0, d_valid=0.
//    All d_* payload outputs=0; f_ready reads 1 once reset is released.
//  Storage: circular buffer of {pc,instr}; wr_ptr/rd_ptr wrap modulo DEPTH.
//    count is tracked separately so full and empty are unambiguous.
//  f_ready = (count<DEPTH) & ~halted & ~flush. No bypass: pop-on-full does not raise f_ready that cycle.
//  Latency: instr pushed at edge N appears at head (d_valid=1) after edge N, so is visible in cycle N+1.
//    Empty queue: no same-cycle passthrough.
//  d_valid = (count!=0).
//    d_* fields are combinational decode of the head entry, stable while d_valid & ~d_ready.
//  Push and pop in the same cycle: count unchanged, both pointers advance.
//  Pop when empty and push when full cannot occur (gated by valid/ready).
//  flush=1 at an edge:
//    wr_ptr=rd_ptr=0, count=0, halted=0.
//    Any same-cycle push and pop are ignored; d_valid=0 the next cycle.
//  HALT: when a HALT entry is popped, halted sets at that edge.
//    f_ready is then held 0 until flush or reset.
//    Entries already queued behind HALT remain and are still delivered.
//  Illegal opcodes are delivered, not dropped: d_illegal=1, d_wr_en=d_is_mem=d_is_branch=0.
//  NOP: all flags 0.
//  Reset mid-operation: all state is lost immediately; no partial entry survives.
// TESTING
//  1 Reset, then push 0x14 @pc=0x10, d_ready=1 -> next cycle d_valid=1, d_pc=0x10, d_op=1, d_rd=1, d_rs=0, d_wr_en=1; then empty.
//  2 d_ready=0, push 4 instrs -> count=4, f_ready=0; 5th offer not accepted; pop order equals push order.
//  3 Full queue, push+pop same cycle -> push refused, count 4->3; steady push/pop at count=2 keeps count=2.
//  4 Queue holds 3 entries, flush=1 with f_valid=1 -> next cycle count=0, d_valid=0, offered instr lost.
//  5 Push 0xF0 then 0x25, pop HALT -> halted=1, f_ready=0; 0x25 still delivered (d_op=2); flush clears halted.
//  6 Push 0xA3 -> d_illegal=1, d_wr_en=0; push 0x6D -> d_is_mem=1, d_wr_en=1, d_rd=3, d_rs=1.
//  7 Assert rst_n=0 with 3 entries queued -> immediately d_valid=0, count=0; after release f_ready=1.

Source files
------------

// File: rtl/instr_queue_decode.sv
// instr_queue_decode
//   Consumer end of the fetch interface. A small circular buffer holds
//   {pc, instr} pairs from fetch. The head entry is decoded and presented
//   to dispatch with a valid/ready handshake. Fetch sees backpressure through
//   f_ready. A branch-redirect flush empties the queue. Popping a HALT stops
//   further intake until a flush or reset.
//
//   Instruction format: instr[7:4] opcode, instr[3:2] rd, instr[1:0] rs.
//   Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 LD, 7 ST, 8 BEQ,
//            F HALT, 9..E illegal.

module instr_queue_decode #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_valid,
  input  logic [7:0]    f_pc,
  input  logic [7:0]    f_instr,
  output logic          f_ready,
  input  logic          flush,
  output logic          d_valid,
  input  logic          d_ready,
  output logic [7:0]    d_pc,
  output logic [3:0]    d_op,
  output logic [1:0]    d_rd,
  output logic [1:0]    d_rs,
  output logic          d_wr_en,
  output logic          d_is_mem,
  output logic          d_is_branch,
  output logic          d_illegal,
  output logic          halted,
  output logic [AW:0]   count
);

  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO = '0;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [3:0]    OP_HALT  = 4'hF;

  // Decoded flag vector for one opcode: {wr_en, is_mem, is_branch, illegal}.
  function automatic logic [3:0] decode_flags(input logic [3:0] op);
    logic [3:0] flags;
    case (op)
      4'h0:    flags = 4'b0000;  // NOP
      4'h1:    flags = 4'b1000;  // ADD
      4'h2:    flags = 4'b1000;  // SUB
      4'h3:    flags = 4'b1000;  // AND
      4'h4:    flags = 4'b1000;  // OR
      4'h5:    flags = 4'b1000;  // XOR
      4'h6:    flags = 4'b1100;  // LD: writes rd, touches memory
      4'h7:    flags = 4'b0100;  // ST
      4'h8:    flags = 4'b0010;  // BEQ
      4'hF:    flags = 4'b0000;  // HALT
      default: flags = 4'b0001;  // 9..E are delivered but marked illegal
    endcase
    return flags;
  endfunction

  // Storage and control state
  logic [7:0]    mem_pc_q    [DEPTH];
  logic [7:0]    mem_instr_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          halted_q, halted_d;

  // Combinational helpers
  logic          f_ready_s;
  logic          d_valid_s;
  logic          push_s;
  logic          pop_s;
  logic [7:0]    head_pc_s;
  logic [7:0]    head_instr_s;
  logic [3:0]    head_flags_s;
  logic          pop_halt_s;

  // Handshake qualification and head-entry lookup
  always_comb begin
    f_ready_s    = (count_q < DEPTH_C) & ~halted_q & ~flush;
    d_valid_s    = (count_q != CNT_ZERO);
    push_s       = f_valid & f_ready_s;
    pop_s        = d_valid_s & d_ready;
    head_pc_s    = mem_pc_q[rd_ptr_q];
    head_instr_s = mem_instr_q[rd_ptr_q];
    head_flags_s = decode_flags(head_instr_s[7:4]);
    pop_halt_s   = pop_s & (head_instr_s[7:4] == OP_HALT);
  end

  // Next-state for pointers, occupancy and the halt latch; flush overrides
  // any same-cycle push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    halted_d = halted_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      halted_d = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;  // idle, or push and pop together
      endcase
      if (pop_halt_s) begin
        halted_d = 1'b1;
      end else begin
        halted_d = halted_q;
      end
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

  // Entry storage: write the offered pair at wr_ptr on an accepted push.
  // push_s already excludes flush because f_ready is low during flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]    <= 8'h00;
        mem_instr_q[i] <= 8'h00;
      end
    end else if (push_s) begin
      mem_pc_q[wr_ptr_q]    <= f_pc;
      mem_instr_q[wr_ptr_q] <= f_instr;
    end
  end

  // Output drive: payload is forced to zero while the queue is empty so
  // dispatch never sees stale fields, and it holds while the head waits.
  always_comb begin
    f_ready = f_ready_s;
    d_valid = d_valid_s;
    halted  = halted_q;
    count   = count_q;
    if (d_valid_s) begin
      d_pc        = head_pc_s;
      d_op        = head_instr_s[7:4];
      d_rd        = head_instr_s[3:2];
      d_rs        = head_instr_s[1:0];
      d_wr_en     = head_flags_s[3];
      d_is_mem    = head_flags_s[2];
      d_is_branch = head_flags_s[1];
      d_illegal   = head_flags_s[0];
    end else begin
      d_pc        = 8'h00;
      d_op        = 4'h0;
      d_rd        = 2'b00;
      d_rs        = 2'b00;
      d_wr_en     = 1'b0;
      d_is_mem    = 1'b0;
      d_is_branch = 1'b0;
      d_illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_queue_decode.sv
// Directed testbench for instr_queue_decode. Inputs are driven and outputs
// sampled on the falling edge, away from the active rising edge.

module tb_instr_queue_decode;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       f_valid;
  logic [7:0] f_pc;
  logic [7:0] f_instr;
  logic       f_ready;
  logic       flush;
  logic       d_valid;
  logic       d_ready;
  logic [7:0] d_pc;
  logic [3:0] d_op;
  logic [1:0] d_rd;
  logic [1:0] d_rs;
  logic       d_wr_en;
  logic       d_is_mem;
  logic       d_is_branch;
  logic       d_illegal;
  logic       halted;
  logic [2:0] count;

  int checks   = 0;
  int failures = 0;

  instr_queue_decode #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr), .f_ready(f_ready),
    .flush(flush),
    .d_valid(d_valid), .d_ready(d_ready), .d_pc(d_pc), .d_op(d_op),
    .d_rd(d_rd), .d_rs(d_rs), .d_wr_en(d_wr_en), .d_is_mem(d_is_mem),
    .d_is_branch(d_is_branch), .d_illegal(d_illegal),
    .halted(halted), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and return at the following falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic offer(input logic [7:0] pc, input logic [7:0] ins);
    f_valid = 1'b1;
    f_pc    = pc;
    f_instr = ins;
  endtask

  initial begin
    rst_n = 1'b0; f_valid = 1'b0; f_pc = 8'h00; f_instr = 8'h00;
    flush = 1'b0; d_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_count", count, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_d_pc", d_pc, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rst_f_ready", f_ready, 1);

    // 1: single ADD through the queue
    offer(8'h10, 8'h14); d_ready = 1'b1;
    cyc(); f_valid = 1'b0;
    chk("t1_d_valid", d_valid, 1);
    chk("t1_d_pc", d_pc, 8'h10);
    chk("t1_d_op", d_op, 1);
    chk("t1_d_rd", d_rd, 1);
    chk("t1_d_rs", d_rs, 0);
    chk("t1_d_wr_en", d_wr_en, 1);
    chk("t1_count", count, 1);
    cyc();
    chk("t1_empty_valid", d_valid, 0);
    chk("t1_empty_count", count, 0);

    // 2: fill to capacity with dispatch stalled
    d_ready = 1'b0;
    offer(8'h20, 8'h11); cyc();
    offer(8'h21, 8'h26); cyc();
    offer(8'h22, 8'h3B); cyc();
    offer(8'h23, 8'h47); cyc();
    chk("t2_count_full", count, 4);
    chk("t2_f_ready_full", f_ready, 0);
    offer(8'h24, 8'h5C); cyc();
    chk("t2_fifth_refused", count, 4);
    chk("t2_head_pc", d_pc, 8'h20);

    // 3: push+pop on a full queue -> push refused, count drops
    d_ready = 1'b1;
    chk("t3_full_f_ready", f_ready, 0);
    cyc();
    chk("t3_count_4to3", count, 3);
    chk("t3_head_pc", d_pc, 8'h21);
    chk("t3_head_op", d_op, 2);
    f_valid = 1'b0; cyc();
    chk("t3_count2", count, 2);
    chk("t3_head_pc2", d_pc, 8'h22);
    chk("t3_head_op3", d_op, 3);
    offer(8'h24, 8'h5C); cyc();
    chk("t3_steady_a", count, 2);
    chk("t3_steady_pc_a", d_pc, 8'h23);
    offer(8'h25, 8'h62); cyc();
    chk("t3_steady_b", count, 2);
    chk("t3_steady_pc_b", d_pc, 8'h24);
    chk("t3_xor_op", d_op, 5);
    chk("t3_xor_rd", d_rd, 3);
    f_valid = 1'b0; cyc();
    chk("t3_ld_pc", d_pc, 8'h25);
    chk("t3_ld_mem", d_is_mem, 1);
    cyc();
    chk("t3_drained", count, 0);

    // 4: flush with three entries and a same-cycle offer
    d_ready = 1'b0;
    offer(8'h30, 8'h01); cyc();
    offer(8'h31, 8'h02); cyc();
    offer(8'h32, 8'h03); cyc();
    chk("t4_count3", count, 3);
    flush = 1'b1; offer(8'h40, 8'h14); d_ready = 1'b1;
    #1 chk("t4_f_ready_flush", f_ready, 0);
    cyc();
    flush = 1'b0; f_valid = 1'b0; d_ready = 1'b0;
    chk("t4_count0", count, 0);
    chk("t4_d_valid0", d_valid, 0);
    cyc();
    chk("t4_offer_lost", count, 0);
    chk("t4_f_ready", f_ready, 1);

    // 5: HALT stops intake; entries behind it still drain; flush clears
    offer(8'h50, 8'hF0); cyc();
    offer(8'h51, 8'h25); cyc();
    f_valid = 1'b0;
    chk("t5_head_halt", d_op, 4'hF);
    chk("t5_halt_flags", {d_wr_en, d_is_mem, d_is_branch, d_illegal}, 0);
    d_ready = 1'b1; cyc();
    chk("t5_halted", halted, 1);
    chk("t5_f_ready0", f_ready, 0);
    chk("t5_next_valid", d_valid, 1);
    chk("t5_next_op", d_op, 2);
    chk("t5_next_pc", d_pc, 8'h51);
    offer(8'h52, 8'h11); cyc();
    f_valid = 1'b0;
    chk("t5_no_push", count, 0);
    chk("t5_still_halted", halted, 1);
    flush = 1'b1; cyc(); flush = 1'b0;
    #1;
    chk("t5_halt_cleared", halted, 0);
    chk("t5_f_ready1", f_ready, 1);

    // 6: illegal, LD, BEQ, ST decode
    d_ready = 1'b0;
    @(negedge clk);
    offer(8'h60, 8'hA3); cyc();
    chk("t6_illegal", d_illegal, 1);
    chk("t6_ill_wr_en", d_wr_en, 0);
    chk("t6_ill_mem", d_is_mem, 0);
    chk("t6_ill_op", d_op, 4'hA);
    d_ready = 1'b1; offer(8'h61, 8'h6D); cyc();
    chk("t6_ld_pc", d_pc, 8'h61);
    chk("t6_ld_mem", d_is_mem, 1);
    chk("t6_ld_wr_en", d_wr_en, 1);
    chk("t6_ld_rd", d_rd, 3);
    chk("t6_ld_rs", d_rs, 1);
    chk("t6_ld_illegal", d_illegal, 0);
    offer(8'h62, 8'h87); cyc();
    chk("t6_beq_branch", d_is_branch, 1);
    chk("t6_beq_wr_en", d_wr_en, 0);
    offer(8'h63, 8'h70); cyc();
    f_valid = 1'b0;
    chk("t6_st_mem", d_is_mem, 1);
    chk("t6_st_wr_en", d_wr_en, 0);
    cyc();
    chk("t6_drained", count, 0);

    // 7: asynchronous reset mid-operation
    d_ready = 1'b0;
    offer(8'h70, 8'h11); cyc();
    offer(8'h71, 8'h22); cyc();
    offer(8'h72, 8'h33); cyc();
    f_valid = 1'b0;
    chk("t7_count3", count, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", d_valid, 0);
    chk("t7_rst_count", count, 0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("t7_f_ready", f_ready, 1);
    @(negedge clk);
    offer(8'h80, 8'h48); cyc();
    f_valid = 1'b0;
    chk("t7_fresh_count", count, 1);
    chk("t7_fresh_pc", d_pc, 8'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
